// File: rtl/cs_pkg.sv
// Shared definitions for the console response framer and its fifoc parser peer:
// state codes, default header bytes and the byte-serial CRC-8 step.
package cs_pkg;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'h00,
    ST_LOAD  = 8'h01,
    ST_WRITE = 8'h02,
    ST_DONE  = 8'h03
  } state_e;

  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hAA;

  // CRC-8, poly 0x07, MSB first, no reflection; one data byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/cs2fifod_frame_chk8.sv
// Frame check accumulator: plain XOR by default, CRC-8 when CS2FIFOD_CRC8_EN is defined.
module frame_chk8
  import cs_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] chk
);

  logic [7:0] chk_q;
  logic [7:0] chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clr) begin
      chk_d = 8'h00;
    end else if (en) begin
`ifdef CS2FIFOD_CRC8_EN
      chk_d = crc8_byte(chk_q, data);
`else
      chk_d = chk_q ^ data;
`endif
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) chk_q <= 8'h00;
    else     chk_q <= chk_d;
  end

  assign chk = chk_q;

endmodule

// File: rtl/cs2fifod.sv
// Console response framer: snapshots status registers on fs and streams one fixed
// frame into the fifod write port. Define CS2FIFOD_CRC8_EN for a CRC-8 trailer byte.
module cs2fifod
  import cs_pkg::*;
#(
  parameter int         PAYLOAD_NUM = 8,
  parameter logic [7:0] HEAD0       = HEAD0_DEF,
  parameter logic [7:0] HEAD1       = HEAD1_DEF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [7:0]  kind_dev,
  input  logic [7:0]  info_sr,
  input  logic [7:0]  reg0,
  input  logic [7:0]  reg1,
  input  logic [7:0]  reg2,
  input  logic [7:0]  reg3,
  input  logic [7:0]  reg4,
  input  logic [7:0]  reg5,
  input  logic [7:0]  reg6,
  input  logic [7:0]  reg7,
  input  logic        fifod_full,
  output logic        fifod_txen,
  output logic [7:0]  fifod_txd,
  output logic [11:0] data_len,
  output logic [7:0]  so
);

  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_NUM + 5);
  localparam logic [3:0] CHK_HI   = 4'(PAYLOAD_NUM + 4);
  localparam logic [7:0] PN_BYTE  = 8'(PAYLOAD_NUM);

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      kind_q, kind_d;
  logic [7:0]      info_q, info_d;
  logic [7:0][7:0] snap_q, snap_d;
  logic [7:0]      frame_byte;
  logic [7:0]      chk_val;
  logic [2:0]      pidx;
  logic            chk_clr;
  logic            chk_en;

  assign data_len = 12'(PAYLOAD_NUM + 6);

  // State register plus snapshot/index datapath
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      kind_q  <= 8'h00;
      info_q  <= 8'h00;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
      info_q  <= info_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fs) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_WRITE;
      ST_WRITE: if (fifod_txen && idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:  if (!fs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write enable is combinational on full so a full fifod is never written.
  always_comb begin
    fd         = (state_q == ST_DONE);
    fifod_txen = (state_q == ST_WRITE) && !fifod_full;
    fifod_txd  = (state_q == ST_WRITE) ? frame_byte : 8'h00;
    so         = state_q;
  end

  always_comb begin
    idx_d  = idx_q;
    kind_d = kind_q;
    info_d = info_q;
    snap_d = snap_q;
    if (state_q == ST_LOAD) begin
      idx_d  = 4'd0;
      kind_d = kind_dev;
      info_d = info_sr;
      snap_d = {reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0};
    end else if (fifod_txen) begin
      idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
    end
  end

  assign pidx = 3'(idx_q - 4'd5);

  always_comb begin
    frame_byte = chk_val;
    if      (idx_q == 4'd0) frame_byte = HEAD0;
    else if (idx_q == 4'd1) frame_byte = HEAD1;
    else if (idx_q == 4'd2) frame_byte = kind_q;
    else if (idx_q == 4'd3) frame_byte = info_q;
    else if (idx_q == 4'd4) frame_byte = PN_BYTE;
    else if (idx_q <= CHK_HI) frame_byte = snap_q[pidx];
  end

  assign chk_clr = (state_q == ST_LOAD);
  assign chk_en  = fifod_txen && (idx_q >= 4'd2) && (idx_q <= CHK_HI);

  frame_chk8 u_chk (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (chk_clr),
    .en      (chk_en),
    .data    (frame_byte),
    .chk     (chk_val)
  );

endmodule

// File: tb/tb_cs2fifod.sv
// Randomized bench for cs2fifod: a frame-level model builds each expected byte stream
// from the inputs present at LOAD and checks order, backpressure, handshake and reset.
module tb_cs2fifod;

  localparam int PN  = 8;
  localparam int LEN = PN + 6;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs = 1'b0;
  logic        fifod_full = 1'b0;
  logic [7:0]  kind_dev = 8'h00;
  logic [7:0]  info_sr = 8'h00;
  logic [7:0]  reg_v [8];
  logic        fd;
  logic        fifod_txen;
  logic [7:0]  fifod_txd;
  logic [11:0] data_len;
  logic [7:0]  so;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  cs2fifod #(.PAYLOAD_NUM(PN)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .fs         (fs),
    .fd         (fd),
    .kind_dev   (kind_dev),
    .info_sr    (info_sr),
    .reg0       (reg_v[0]),
    .reg1       (reg_v[1]),
    .reg2       (reg_v[2]),
    .reg3       (reg_v[3]),
    .reg4       (reg_v[4]),
    .reg5       (reg_v[5]),
    .reg6       (reg_v[6]),
    .reg7       (reg_v[7]),
    .fifod_full (fifod_full),
    .fifod_txen (fifod_txen),
    .fifod_txd  (fifod_txd),
    .data_len   (data_len),
    .so         (so)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Bitwise shift-register CRC-8 (poly 0x07), MSB first.
  function automatic logic [7:0] model_crc(input logic [7:0] b[$]);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    foreach (b[j]) begin
      for (int i = 7; i >= 0; i--) begin
        fb  = crc[7] ^ b[j][i];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return crc;
  endfunction

  task automatic scramble_inputs();
    kind_dev = 8'($urandom);
    info_sr  = 8'($urandom);
    for (int i = 0; i < 8; i++) reg_v[i] = 8'($urandom);
  endtask

  // mode 0: no stall, 1: stall stall_len cycles at byte index stall_at, 2: random stalls
  task automatic run_frame(input bit directed, input int mode, input int stall_at,
                           input int stall_len, input bit abort, input int hold_done);
    logic [7:0] exp [LEN];
    logic [7:0] body [$];
    logic [7:0] chk;
    logic [7:0] txd_s;
    bit         txen_s;
    int         n, iters, fulls, stalled;

    @(posedge sys_clk); #1;
    if (directed) begin
      kind_dev = 8'h01;
      info_sr  = 8'h02;
      for (int i = 0; i < 8; i++) reg_v[i] = 8'(8'h11 * (i + 1));
    end else begin
      scramble_inputs();
    end
    exp[0] = 8'h55;
    exp[1] = 8'hAA;
    exp[2] = kind_dev;
    exp[3] = info_sr;
    exp[4] = 8'(PN);
    for (int i = 0; i < PN; i++) exp[5 + i] = reg_v[i];
    for (int j = 2; j <= LEN - 2; j++) body.push_back(exp[j]);
`ifdef CS2FIFOD_CRC8_EN
    chk = model_crc(body);
`else
    chk = 8'h00;
    foreach (body[j]) chk ^= body[j];
    if (directed) chk = 8'h83;
`endif
    exp[LEN - 1] = chk;
    fs = 1'b1;

    @(posedge sys_clk); #1;
    check("so_load", so, 8'h01);
    @(posedge sys_clk); #1;
    if (directed) reg_v[3] = 8'hFF;
    else scramble_inputs();

    n = 0; iters = 0; fulls = 0; stalled = 0;
    fifod_full = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    while (n < LEN && iters < 200) begin
      @(negedge sys_clk);
      txen_s = fifod_txen;
      txd_s  = fifod_txd;
      check("txen_vs_full", {31'd0, txen_s}, {31'd0, !fifod_full});
      check("fd_busy", {31'd0, fd}, 32'd0);
      if (txen_s) check($sformatf("byte%0d", n), txd_s, exp[n]);
      if (fifod_full) fulls++;
      @(posedge sys_clk);
      iters++;
      if (txen_s) n++;
      #1;
      if (abort && n == 7) begin
        rst = 1'b1;
        fs = 1'b0;
        fifod_full = 1'b0;
        #1;
        check("abort_txen", {31'd0, fifod_txen}, 32'd0);
        check("abort_fd", {31'd0, fd}, 32'd0);
        check("abort_so", so, 8'h00);
        check("abort_txd", fifod_txd, 8'h00);
        @(negedge sys_clk);
        rst = 1'b0;
        return;
      end
      case (mode)
        1: begin
          if (n == stall_at && stalled < stall_len) begin
            fifod_full = 1'b1;
            stalled++;
          end else begin
            fifod_full = 1'b0;
          end
        end
        2:       fifod_full = ($urandom_range(0, 3) == 0);
        default: fifod_full = 1'b0;
      endcase
      if (n >= LEN) fifod_full = 1'b0;
    end
    check("frame_cycles", iters, LEN + fulls);

    @(negedge sys_clk);
    check("fd_done", {31'd0, fd}, 32'd1);
    check("so_done", so, 8'h03);
    check("txen_done", {31'd0, fifod_txen}, 32'd0);
    check("data_len", {20'd0, data_len}, LEN);
    for (int h = 0; h < hold_done; h++) begin
      @(negedge sys_clk);
      check("fd_hold", {31'd0, fd}, 32'd1);
      check("so_hold", so, 8'h03);
      check("txen_hold", {31'd0, fifod_txen}, 32'd0);
    end
    @(posedge sys_clk); #1;
    fs = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("fd_drop", {31'd0, fd}, 32'd0);
    check("so_idle", so, 8'h00);
    @(negedge sys_clk);
    check("stay_idle", so, 8'h00);
    check("txen_idle", {31'd0, fifod_txen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) reg_v[i] = 8'h00;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_fd", {31'd0, fd}, 32'd0);
    check("rst_txen", {31'd0, fifod_txen}, 32'd0);
    check("rst_txd", fifod_txd, 8'h00);
    check("rst_so", so, 8'h00);
    check("rst_data_len", {20'd0, data_len}, LEN);
    rst = 1'b0;

    run_frame(1'b1, 0, 0, 0, 1'b0, 0);
    run_frame(1'b1, 1, 5, 3, 1'b0, 5);
    run_frame(1'b1, 0, 0, 0, 1'b1, 0);
    run_frame(1'b1, 0, 0, 0, 1'b0, 1);
    for (int r = 0; r < 10; r++) begin
      run_frame(1'b0, (r % 3 == 0) ? 1 : 2, $urandom_range(0, LEN - 1),
                $urandom_range(1, 4), 1'b0, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cs2fifod.md
Name: cs2fifod

Overview:
- Console-side response framer in the sys_clk domain. It is the writer counterpart of the command parser that reads fifoc.
- On a start request it snapshots device/status registers and builds one fixed-format response frame. It writes the frame byte-by-byte into the fifod write port, honouring fifod full.
- It reports the frame length so the downstream fifod-to-MAC reader can size the UDP packet.
- It is driven by the top-level console state machine with the usual fs/fd level handshake.

Parameters:
- PAYLOAD_NUM, 8, number of payload register bytes in the frame; legal range 1..8; uses reg0..reg(PAYLOAD_NUM-1).
- HEAD0, 8'h55, first header byte.
- HEAD1, 8'hAA, second header byte.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- fs  in  1  start request, level, held by controller until fd seen.
- fd  out  1  frame complete, level.
- kind_dev  in  8  device kind byte.
- info_sr  in  8  sample-rate/info byte.
- reg0..reg7  in  8 each  payload bytes.
- fifod_full  in  1  fifod full flag (write side, sys_clk).
- fifod_txen  out  1  fifod write enable.
- fifod_txd  out  8  fifod write data.
- data_len  out  12  total frame length in bytes.
- so  out  8  current state code, for debug/ILA.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - fd=0, fifod_txen=0, fifod_txd=8'h00, so=IDLE code.
  - Byte index, checksum and snapshot registers are cleared to 0.
  - data_len is a constant 12'(PAYLOAD_NUM+6) at all times, including during reset.
- Frame layout, index 0..PAYLOAD_NUM+5:
  - 0: HEAD0
  - 1: HEAD1
  - 2: kind_dev
  - 3: info_sr
  - 4: PAYLOAD_NUM as an 8-bit value
  - 5..PAYLOAD_NUM+4: reg0.. in ascending order
  - PAYLOAD_NUM+5: checksum
- Checksum: XOR of bytes at index 2..PAYLOAD_NUM+4. It accumulates into a register as each byte is written.
- States (so codes): IDLE=8'h00, LOAD=8'h01, WRITE=8'h02, DONE=8'h03.
- IDLE:
  - If fs=1 at a clock edge, go to LOAD. Otherwise stay.
- LOAD (exactly 1 cycle):
  - Latch kind_dev, info_sr and reg0..reg7 into the snapshot.
  - Clear index and checksum.
  - Go to WRITE.
  - Input changes after this edge do not affect the frame.
- WRITE:
  - fifod_txen = (state==WRITE) && !fifod_full. This is combinational so that full takes effect in the same cycle and overflow is impossible.
  - fifod_txd = frame byte[index], from the snapshot, combinational mux.
  - On each edge with txen=1: index increments, and the checksum updates if index is in 2..PAYLOAD_NUM+4.
  - When txen=1 and index==PAYLOAD_NUM+5: go to DONE and clear index.
  - While fifod_full=1: no write, index and checksum held, state held. There is no timeout.
- DONE:
  - fd=1 (decode of state).
  - When fs=0, go to IDLE on the next edge. fd drops in that same cycle.
- fs deasserted during LOAD/WRITE: ignored; the frame always completes.
- fs still high in DONE: remain in DONE. No second frame until fs has been seen low.
- Latency, no stall: fs sampled at edge k → WRITE from edge k+1 → bytes written at edges k+2..k+PAYLOAD_NUM+7 → fd=1 after edge k+PAYLOAD_NUM+7.
- Reset mid-frame: immediate abort to IDLE. A partial frame may remain in fifod; the top level resets fifod alongside.
- Widths: index is 4 bits (max 13); checksum is 8 bits.

Optional Feature:
- Macro CS2FIFOD_CRC8_EN.
  - When defined: the final byte is CRC-8 over the same byte range, polynomial 0x07, init 8'h00, MSB first, no reflection, no final XOR. It is computed byte-serially with the package function.
  - When undefined: plain XOR checksum.
- Frame length, timing and all other behaviour are identical in both builds.

Decomposition:
- Shared package cs_pkg:
  - state codes (IDLE/LOAD/WRITE/DONE)
  - HEAD0/HEAD1 default constants
  - function crc8_byte(crc, data), so the fifoc2cs parser can reuse it for checking
- Natural sub-module: frame_chk8. It is the checksum/CRC accumulator with clear/enable/data inputs and an 8-bit result; it contains the CRC8_EN selection.

Test Plan:
- Basic frame (XOR), PAYLOAD_NUM=8, kind_dev=01, info_sr=02, reg0..7=11,22,...,88, fifod_full=0, fs high → fifod_txd sequence 55 AA 01 02 08 11 22 33 44 55 66 77 88 83 on 14 consecutive txen cycles; fd=1 after edge k+15; data_len=12'h00E.
- Backpressure: same stimulus, fifod_full=1 for 3 cycles while index=5 → txen=0 for those 3 cycles, byte 11 not duplicated or lost, fd 3 cycles later (edge k+18).
- Handshake: fs kept high 5 cycles in DONE, then dropped → fd stays 1, no new frame; IDLE one edge after fs=0; fd=0 in that same cycle.
- Snapshot: change reg3 from 44 to FF one cycle after LOAD → frame still carries 44 and checksum 83.
- Reset mid-frame: rst pulse at index 7 → txen=0, fd=0, so=00 immediately; next fs yields a complete correct frame.
- CRC build (CS2FIFOD_CRC8_EN), PAYLOAD_NUM=1, kind_dev=00, info_sr=00, reg0=00 → bytes 55 AA 00 00 01 00 then CRC-8 of {00,00,01,00} = 8'h15; data_len=12'h007.
